encrypter_feeder: RTL and testbench
===================================

ENCRYPTER_FEEDER -- requirements
Module: encrypter_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning plaintext/key word width (equals `ENCRYPTER_WIDTH and `KEY_WIDTH).
REQ-002 The block SHALL have parameter ROT_WIDTH, default 5, meaning rotation-offset width (equals `KEY_ROTATION_WIDTH).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8 (power of two), meaning plaintext buffer entries.
REQ-004 The block SHALL have parameter ROT_STEP, default 1, meaning offset increment per word sent.
REQ-005 The block SHALL have the following ports, one per line, as name, direction, width, meaning:
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- keyIn  in  DATA_WIDTH  key from host
- keyLoad  in  1  one-cycle key load request
- wrData  in  DATA_WIDTH  plaintext word from host
- wrEn  in  1  push wrData into FIFO
- full  out  1  FIFO full
- count  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky, write attempted while full
- encReqIn  in  1  encrypter reqIn (wants data)
- encData  out  DATA_WIDTH  drives encrypter dataIn
- encRotOffset  out  ROT_WIDTH  drives encrypter rot_offset
- encProg  out  1  drives encrypter prog
- encRdyIn  out  1  drives encrypter rdyIn
- busy  out  1  state not IDLE/WAIT_REQ
- wordsSent  out  16  words delivered, wraps at 65535->0

Function
REQ-006 All outputs SHALL be registered; no combinational path from any input to encProg, encRdyIn, encData or encRotOffset.
REQ-007 FSM states SHALL be IDLE, LOAD_KEY, WAIT_REQ, PRESENT, RELEASE.
REQ-008 IDLE: keyLoad -> latch keyIn, offset counter := 0, go LOAD_KEY; data words not sent until a key has been loaded (keyValid=0).
REQ-009 LOAD_KEY: encData = latched key, encProg = 1 for exactly 2 cycles, encData held stable 1 further cycle with encProg = 0; then keyValid := 1, go WAIT_REQ.
REQ-010 WAIT_REQ: when encReqIn = 1 and count > 0 -> encData := FIFO head, encRotOffset := offset counter, go PRESENT; keyLoad in WAIT_REQ -> go LOAD_KEY as in REQ-008.
REQ-011 PRESENT: encRdyIn = 1, encData/encRotOffset held stable; on encReqIn falling (sampled 1 then 0) -> pop FIFO, wordsSent += 1, offset := (offset + ROT_STEP) mod 2^ROT_WIDTH, go RELEASE.
REQ-012 RELEASE: encRdyIn = 0 for 1 cycle; then go LOAD_KEY if keyPending, else WAIT_REQ.
REQ-013 keyLoad while in LOAD_KEY, PRESENT or RELEASE SHALL latch keyIn into a pending register and set keyPending; the later request overwrites an earlier pending one; keyPending clears on entry to LOAD_KEY.
REQ-014 Presented word SHALL never be changed or popped before encReqIn falls; encReqIn staying high holds PRESENT indefinitely.
REQ-015 FIFO write with full = 1 SHALL be dropped and set overflow, even if a pop occurs the same cycle.
REQ-016 Simultaneous non-full write and pop SHALL leave count unchanged; data order strictly FIFO.
REQ-017 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full = (count == FIFO_DEPTH).
REQ-018 Offset counter SHALL wrap 2^ROT_WIDTH-1 -> ROT_STEP-1 modulo 2^ROT_WIDTH without glitching encRotOffset outside PRESENT.

Reset
REQ-019 reset = 1 at a rising clk edge SHALL force IDLE, encProg = 0, encRdyIn = 0, encData = 0, encRotOffset = 0, count = 0, full = 0, overflow = 0, busy = 0, wordsSent = 0, keyValid = 0, keyPending = 0, offset = 0.
REQ-020 Reset mid-PRESENT SHALL drop encRdyIn the next cycle and discard all buffered words; reset has priority over every other input.

Verification
REQ-021 Key load: keyIn=0xA5A5_0F0F, keyLoad pulse in IDLE -> encProg high 2 cycles, encData=0xA5A5_0F0F for 3 cycles, then WAIT_REQ.
REQ-022 Single word: push 0x1234_5678, encReqIn=1 -> encRdyIn=1, encData=0x1234_5678, encRotOffset=0; drop encReqIn -> encRdyIn low 1 cycle later, wordsSent=1, count=0.
REQ-023 Burst with offset: 4 words, 4 handshakes -> encRotOffset 0,1,2,3 in order, data in push order.
REQ-024 Overflow: 9 pushes with FIFO_DEPTH=8, no requests -> full=1, count=8, overflow=1, 9th word never presented.
REQ-025 Key change mid-transfer: keyLoad during PRESENT -> word completes, RELEASE, then LOAD_KEY with new key, offset restarts at 0.
REQ-026 Offset wrap: 33 words, ROT_WIDTH=5 -> 33rd word presented with encRotOffset=0.

Source files
------------

// File: rtl/encrypter_feeder.sv
// encrypter_feeder: buffers host plaintext in a small FIFO and feeds it, one
// word per handshake, to an encrypter core, after first programming it with a
// key. Each delivered word carries a rotation offset that advances by ROT_STEP
// and restarts at 0 whenever a new key is programmed.
//
// Ports:
//   clk, reset            - sole clock; synchronous active-high reset
//   keyIn, keyLoad        - host key and one-cycle load request
//   wrData, wrEn          - host plaintext push
//   full, count, overflow - FIFO status (overflow is sticky)
//   encReqIn              - encrypter wants data (falling edge = word taken)
//   encData, encRotOffset - word / offset presented to the encrypter
//   encProg, encRdyIn     - key-program strobe and data-ready to the encrypter
//   busy                  - FSM is outside IDLE/WAIT_REQ
//   wordsSent             - delivered-word counter (wraps)
// All outputs come straight from flops.
module encrypter_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ROT_WIDTH  = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int ROT_STEP   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         keyIn,
  input  logic                          keyLoad,
  input  logic [DATA_WIDTH-1:0]         wrData,
  input  logic                          wrEn,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          encReqIn,
  output logic [DATA_WIDTH-1:0]         encData,
  output logic [ROT_WIDTH-1:0]          encRotOffset,
  output logic                          encProg,
  output logic                          encRdyIn,
  output logic                          busy,
  output logic [15:0]                   wordsSent
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD_KEY, WAIT_REQ, PRESENT, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            ld_cnt_q, ld_cnt_d;
  logic [DATA_WIDTH-1:0] key_q, key_d, pend_key_q, pend_key_d;
  logic                  key_pend_q, key_pend_d, key_valid_q, key_valid_d;
  logic [ROT_WIDTH-1:0]  offset_q, offset_d;
  logic                  pop, push, enter_load;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d, ovf_q, ovf_d;
  logic [15:0]           words_q, words_d;

  logic [DATA_WIDTH-1:0] enc_data_q, enc_data_d;
  logic [ROT_WIDTH-1:0]  enc_rot_q, enc_rot_d;
  logic                  enc_prog_q, enc_prog_d, enc_rdy_q, enc_rdy_d, busy_q, busy_d;

  // State register (also holds all other flops)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ld_cnt_q    <= '0;
      key_q       <= '0;
      pend_key_q  <= '0;
      key_pend_q  <= 1'b0;
      key_valid_q <= 1'b0;
      offset_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      words_q     <= '0;
      enc_data_q  <= '0;
      enc_rot_q   <= '0;
      enc_prog_q  <= 1'b0;
      enc_rdy_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      key_q       <= key_d;
      pend_key_q  <= pend_key_d;
      key_pend_q  <= key_pend_d;
      key_valid_q <= key_valid_d;
      offset_q    <= offset_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      words_q     <= words_d;
      enc_data_q  <= enc_data_d;
      enc_rot_q   <= enc_rot_d;
      enc_prog_q  <= enc_prog_d;
      enc_rdy_q   <= enc_rdy_d;
      busy_q      <= busy_d;
    end
  end

  // Storage needs no reset: pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wrData;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    key_d       = key_q;
    pend_key_d  = pend_key_q;
    key_pend_d  = key_pend_q;
    key_valid_d = key_valid_q;
    offset_d    = offset_q;
    pop         = 1'b0;
    enter_load  = 1'b0;
    case (state_q)
      IDLE: if (keyLoad) begin
        key_d      = keyIn;
        enter_load = 1'b1;
      end
      LOAD_KEY: begin
        if (keyLoad) begin
          pend_key_d = keyIn;
          key_pend_d = 1'b1;
        end
        // ld_cnt 0,1: prog high; 2: key held with prog low
        if (ld_cnt_q == 2'd2) begin
          state_d     = WAIT_REQ;
          key_valid_d = 1'b1;
        end else begin
          ld_cnt_d = ld_cnt_q + 2'd1;
        end
      end
      WAIT_REQ: begin
        // A key arriving in the last LOAD_KEY cycle is still pending here.
        if (keyLoad) begin
          key_d      = keyIn;
          enter_load = 1'b1;
        end else if (key_pend_q) begin
          key_d      = pend_key_q;
          enter_load = 1'b1;
        end else if (encReqIn && count_q != '0 && key_valid_q) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (keyLoad) begin
          pend_key_d = keyIn;
          key_pend_d = 1'b1;
        end
        // PRESENT is only entered with encReqIn high, so a low sample here
        // is always a falling edge.
        if (!encReqIn) begin
          pop      = 1'b1;
          offset_d = offset_q + ROT_WIDTH'(ROT_STEP);
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        // A keyLoad in this cycle is the newest key and wins over pending.
        if (keyLoad || key_pend_q) begin
          key_d      = keyLoad ? keyIn : pend_key_q;
          enter_load = 1'b1;
        end else begin
          state_d = WAIT_REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_load) begin
      state_d    = LOAD_KEY;
      ld_cnt_d   = '0;
      offset_d   = '0;
      key_pend_d = 1'b0;
    end
  end

  // FIFO bookkeeping; a write while full is dropped even alongside a pop.
  always_comb begin
    push     = wrEn && !full_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (count_d == CNT_W'(FIFO_DEPTH));
    ovf_d    = ovf_q | (wrEn && full_q);
    words_d  = pop ? words_q + 16'd1 : words_q;
  end

  // Output logic, registered from the next state
  always_comb begin
    enc_data_d = enc_data_q;
    enc_rot_d  = enc_rot_q;
    enc_prog_d = (state_d == LOAD_KEY) && (ld_cnt_d != 2'd2);
    enc_rdy_d  = (state_d == PRESENT);
    busy_d     = !(state_d == IDLE || state_d == WAIT_REQ);
    if (state_d == LOAD_KEY) begin
      enc_data_d = key_d;
    end else if (state_q == WAIT_REQ && state_d == PRESENT) begin
      enc_data_d = mem_q[rd_ptr_q];
      enc_rot_d  = offset_q;
    end
  end

  assign full         = full_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign encData      = enc_data_q;
  assign encRotOffset = enc_rot_q;
  assign encProg      = enc_prog_q;
  assign encRdyIn     = enc_rdy_q;
  assign busy         = busy_q;
  assign wordsSent    = words_q;
endmodule

// File: tb/tb_encrypter_feeder.sv
module tb_encrypter_feeder;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] keyIn = '0, wrData = '0;
  logic        keyLoad = 1'b0, wrEn = 1'b0, encReqIn = 1'b0;
  logic        full, overflow, encProg, encRdyIn, busy;
  logic [3:0]  count;
  logic [31:0] encData;
  logic [4:0]  encRotOffset;
  logic [15:0] wordsSent;
  int          tests = 0, fails = 0;
  logic [15:0] exp_words = '0;

  encrypter_feeder dut (
    .clk(clk), .reset(reset), .keyIn(keyIn), .keyLoad(keyLoad),
    .wrData(wrData), .wrEn(wrEn), .full(full), .count(count),
    .overflow(overflow), .encReqIn(encReqIn), .encData(encData),
    .encRotOffset(encRotOffset), .encProg(encProg), .encRdyIn(encRdyIn),
    .busy(busy), .wordsSent(wordsSent)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input logic [31:0] k);
    keyIn = k; keyLoad = 1'b1; tick(); keyLoad = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic push(input logic [31:0] d);
    wrData = d; wrEn = 1'b1; tick(); wrEn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    tests++; if (encProg !== 1'b0) begin fails++; $display("FAIL reset_prog got=%0h exp=0", encProg); end
    tests++; if (encRdyIn !== 1'b0) begin fails++; $display("FAIL reset_rdy got=%0h exp=0", encRdyIn); end
    tests++; if (encData !== 32'h0) begin fails++; $display("FAIL reset_data got=%0h exp=0", encData); end
    tests++; if (encRotOffset !== 5'd0) begin fails++; $display("FAIL reset_rot got=%0h exp=0", encRotOffset); end
    tests++; if (count !== 4'd0 || full !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL reset_fifo count=%0d full=%0b ovf=%0b exp=0/0/0", count, full, overflow); end
    tests++; if (busy !== 1'b0 || wordsSent !== 16'd0) begin fails++; $display("FAIL reset_busy_words busy=%0b words=%0d exp=0/0", busy, wordsSent); end
    reset = 1'b0; tick();
    // No key yet: a buffered word and a request must not be presented.
    push(32'hDEAD0001); encReqIn = 1'b1; tick(); tick();
    tests++; if (encRdyIn !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL nokey_rdy rdy=%0b busy=%0b exp=0/0", encRdyIn, busy); end
    encReqIn = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic test_key_load();
    keyIn = 32'hA5A5_0F0F; keyLoad = 1'b1; tick(); keyLoad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (encProg !== (i < 2)) begin fails++; $display("FAIL keyload_prog cyc=%0d got=%0b exp=%0b", i, encProg, (i < 2)); end
      tests++; if (encData !== 32'hA5A5_0F0F) begin fails++; $display("FAIL keyload_data cyc=%0d got=%0h exp=a5a50f0f", i, encData); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL keyload_busy cyc=%0d got=%0b exp=1", i, busy); end
      tick();
    end
    tests++; if (busy !== 1'b0 || encProg !== 1'b0) begin fails++; $display("FAIL keyload_wait busy=%0b prog=%0b exp=0/0", busy, encProg); end
  endtask

  task automatic test_single_word();
    push(32'h1234_5678);
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL single_count got=%0d exp=1", count); end
    encReqIn = 1'b1; tick();
    tests++; if (encRdyIn !== 1'b1 || encData !== 32'h1234_5678 || encRotOffset !== 5'd0) begin fails++; $display("FAIL single_present rdy=%0b data=%0h rot=%0d exp=1/12345678/0", encRdyIn, encData, encRotOffset); end
    tick(); tick(); tick();
    tests++; if (encRdyIn !== 1'b1 || encData !== 32'h1234_5678 || count !== 4'd1) begin fails++; $display("FAIL single_hold rdy=%0b data=%0h count=%0d exp=1/12345678/1", encRdyIn, encData, count); end
    encReqIn = 1'b0; tick(); exp_words++;
    tests++; if (encRdyIn !== 1'b0 || wordsSent !== exp_words || count !== 4'd0) begin fails++; $display("FAIL single_release rdy=%0b words=%0d count=%0d exp=0/%0d/0", encRdyIn, wordsSent, count, exp_words); end
    tick();
    tests++; if (busy !== 1'b0 || encRdyIn !== 1'b0) begin fails++; $display("FAIL single_wait busy=%0b rdy=%0b exp=0/0", busy, encRdyIn); end
  endtask

  task automatic test_burst();
    load_key(32'h1111_2222);
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + i);
    tests++; if (count !== 4'd4) begin fails++; $display("FAIL burst_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      encReqIn = 1'b1; tick();
      tests++; if (encRdyIn !== 1'b1 || encData !== 32'hA000_0000 + i || encRotOffset !== 5'(i)) begin fails++; $display("FAIL burst_word i=%0d rdy=%0b data=%0h rot=%0d exp=1/%0h/%0d", i, encRdyIn, encData, encRotOffset, 32'hA000_0000 + i, i); end
      encReqIn = 1'b0; tick(); exp_words++; tick();
    end
    tests++; if (wordsSent !== exp_words || count !== 4'd0) begin fails++; $display("FAIL burst_end words=%0d count=%0d exp=%0d/0", wordsSent, count, exp_words); end
  endtask

  task automatic test_overflow();
    // Offset stands at 4 after the burst.
    for (int i = 0; i < 9; i++) push(32'hB000_0000 + i);
    tests++; if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_state full=%0b count=%0d ovf=%0b exp=1/8/1", full, count, overflow); end
    encReqIn = 1'b1; tick();
    tests++; if (encData !== 32'hB000_0000 || encRotOffset !== 5'd4) begin fails++; $display("FAIL ovf_first data=%0h rot=%0d exp=b0000000/4", encData, encRotOffset); end
    // Write while full, same cycle as the pop: must be dropped.
    encReqIn = 1'b0; wrData = 32'hEEEE_EEEE; wrEn = 1'b1; tick(); wrEn = 1'b0; exp_words++;
    tests++; if (count !== 4'd7 || full !== 1'b0) begin fails++; $display("FAIL ovf_pop_drop count=%0d full=%0b exp=7/0", count, full); end
    tick();
    for (int i = 1; i < 8; i++) begin
      encReqIn = 1'b1; tick();
      tests++; if (encRdyIn !== 1'b1 || encData !== 32'hB000_0000 + i || encRotOffset !== 5'(4 + i)) begin fails++; $display("FAIL ovf_drain i=%0d rdy=%0b data=%0h rot=%0d exp=1/%0h/%0d", i, encRdyIn, encData, encRotOffset, 32'hB000_0000 + i, 4 + i); end
      encReqIn = 1'b0; tick(); exp_words++; tick();
    end
    tests++; if (count !== 4'd0 || overflow !== 1'b1 || wordsSent !== exp_words) begin fails++; $display("FAIL ovf_end count=%0d ovf=%0b words=%0d exp=0/1/%0d", count, overflow, wordsSent, exp_words); end
    encReqIn = 1'b1; tick(); tick();
    tests++; if (encRdyIn !== 1'b0) begin fails++; $display("FAIL ovf_empty_req rdy=%0b exp=0", encRdyIn); end
    encReqIn = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    // Offset stands at 12.
    push(32'hC000_0000); push(32'hC000_0001);
    encReqIn = 1'b1; tick();
    tests++; if (encData !== 32'hC000_0000 || encRotOffset !== 5'd12) begin fails++; $display("FAIL b2b_first data=%0h rot=%0d exp=c0000000/12", encData, encRotOffset); end
    encReqIn = 1'b0; wrData = 32'hC000_0002; wrEn = 1'b1; tick(); wrEn = 1'b0; exp_words++;
    tests++; if (count !== 4'd2) begin fails++; $display("FAIL b2b_push_pop count=%0d exp=2", count); end
    tick();
    for (int i = 1; i < 3; i++) begin
      encReqIn = 1'b1; tick();
      tests++; if (encData !== 32'hC000_0000 + i || encRotOffset !== 5'(12 + i)) begin fails++; $display("FAIL b2b_word i=%0d data=%0h rot=%0d exp=%0h/%0d", i, encData, encRotOffset, 32'hC000_0000 + i, 12 + i); end
      encReqIn = 1'b0; tick(); exp_words++; tick();
    end
    tests++; if (count !== 4'd0 || wordsSent !== exp_words) begin fails++; $display("FAIL b2b_end count=%0d words=%0d exp=0/%0d", count, wordsSent, exp_words); end
  endtask

  task automatic test_key_change();
    // Offset stands at 15.
    push(32'hD000_0000);
    encReqIn = 1'b1; tick();
    keyIn = 32'h0BAD_F00D; keyLoad = 1'b1; tick(); keyLoad = 1'b0;
    tests++; if (encRdyIn !== 1'b1 || encData !== 32'hD000_0000 || encRotOffset !== 5'd15 || encProg !== 1'b0) begin fails++; $display("FAIL keychg_hold rdy=%0b data=%0h rot=%0d prog=%0b exp=1/d0000000/15/0", encRdyIn, encData, encRotOffset, encProg); end
    encReqIn = 1'b0; tick(); exp_words++;
    tests++; if (encRdyIn !== 1'b0 || encProg !== 1'b0 || wordsSent !== exp_words) begin fails++; $display("FAIL keychg_release rdy=%0b prog=%0b words=%0d exp=0/0/%0d", encRdyIn, encProg, wordsSent, exp_words); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (encProg !== (i < 2) || encData !== 32'h0BAD_F00D) begin fails++; $display("FAIL keychg_load cyc=%0d prog=%0b data=%0h exp=%0b/0badf00d", i, encProg, encData, (i < 2)); end
    end
    tick();
    push(32'hE000_0000);
    encReqIn = 1'b1; tick();
    tests++; if (encData !== 32'hE000_0000 || encRotOffset !== 5'd0) begin fails++; $display("FAIL keychg_newoff data=%0h rot=%0d exp=e0000000/0", encData, encRotOffset); end
    encReqIn = 1'b0; tick(); exp_words++; tick();
  endtask

  task automatic test_offset_wrap();
    load_key(32'h5555_AAAA);
    for (int i = 0; i < 33; i++) begin
      push(32'hF100_0000 + i);
      encReqIn = 1'b1; tick();
      tests++; if (encData !== 32'hF100_0000 + i || encRotOffset !== 5'(i % 32)) begin fails++; $display("FAIL wrap_word i=%0d data=%0h rot=%0d exp=%0h/%0d", i, encData, encRotOffset, 32'hF100_0000 + i, i % 32); end
      encReqIn = 1'b0; tick(); exp_words++; tick();
    end
    tests++; if (wordsSent !== exp_words) begin fails++; $display("FAIL wrap_words got=%0d exp=%0d", wordsSent, exp_words); end
  endtask

  task automatic test_reset_mid_present();
    push(32'hF000_0000); push(32'hF000_0001);
    encReqIn = 1'b1; tick();
    tests++; if (encRdyIn !== 1'b1) begin fails++; $display("FAIL rstmid_pre rdy=%0b exp=1", encRdyIn); end
    reset = 1'b1; tick(); reset = 1'b0;
    tests++; if (encRdyIn !== 1'b0 || count !== 4'd0 || full !== 1'b0 || overflow !== 1'b0) begin fails++; $display("FAIL rstmid_fifo rdy=%0b count=%0d full=%0b ovf=%0b exp=0/0/0/0", encRdyIn, count, full, overflow); end
    tests++; if (busy !== 1'b0 || wordsSent !== 16'd0 || encData !== 32'h0 || encRotOffset !== 5'd0) begin fails++; $display("FAIL rstmid_out busy=%0b words=%0d data=%0h rot=%0d exp=0/0/0/0", busy, wordsSent, encData, encRotOffset); end
    tick(); tick();
    tests++; if (encRdyIn !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_after rdy=%0b busy=%0b exp=0/0", encRdyIn, busy); end
    encReqIn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_key_load();
    test_single_word();
    test_burst();
    test_overflow();
    test_back_to_back();
    test_key_change();
    test_offset_wrap();
    test_reset_mid_present();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
